// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until done.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [63:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_q;

  logic            accept;
  logic            clamp;
  logic [CW-1:0]   word_idx_inc;
  logic [63:0]     addr_now;

  assign accept       = (state == RECV) && byte_valid && byte_ready;
  assign clamp        = (word_count > MAX_WORDS);
  assign word_idx_inc = word_idx + 1'b1;
  // word_idx never reaches count_q inside WRITE, so no address wrap is possible.
  assign addr_now     = BASE_ADDR + 64'({word_idx, 2'b00});

  // NOTE: every register here uses non-blocking assignment so all state
  // advances together on the edge; the partial-word register is reset too so
  // an aborted load cannot leak stale bytes into the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count_q    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_hold  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;

      case (state)
        IDLE: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          if (start) begin
            count_q   <= clamp ? MAX_WORDS : word_count;
            error     <= clamp;
            word_idx  <= '0;
            byte_idx  <= '0;
            core_hold <= 1'b1;
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= RECV;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end

        RECV: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              default: begin
                state      <= WRITE;
                byte_ready <= 1'b0;
                wr_en      <= 1'b1;
                wr_data    <= {byte_data, asm_q};
                wr_addr    <= addr_now;
              end
            endcase
          end
        end

        WRITE: begin
          word_idx <= word_idx_inc;
          if (word_idx_inc == count_q) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          core_hold <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
